// File: rtl/btn_debounce_pkg.sv
// Shared defaults and sizing helper for the button debouncer.
package btn_debounce_pkg;

  localparam int unsigned DEF_WIDTH          = 6;
  localparam int unsigned DEF_SYNC_STAGES    = 2;
  localparam int unsigned DEF_TICK_DIV       = 500;
  localparam int unsigned DEF_DEBOUNCE_TICKS = 100;

  // Bits needed to count 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce_chan.sv
// One debounce channel: synchronizer, stability counter, optional edge strobes.
// Strobes exist only when BTN_DEBOUNCE_EDGE_EN is defined.
module btn_debounce_chan
  import btn_debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter logic        INIT_BIT       = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_i,
  input  logic tick_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_TICKS);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;

  assign sync = sync_q[SYNC_STAGES-1];

  // Counter only advances while the synchronized input disagrees with the accepted level.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync == level_q) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == CNT_W'(DEBOUNCE_TICKS - 1)) begin
        level_d = sync;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= {SYNC_STAGES{INIT_BIT}};
      cnt_q   <= '0;
      level_q <= INIT_BIT;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

`ifdef BTN_DEBOUNCE_EDGE_EN
  logic rise_q, fall_q;

  // Strobes register alongside level_q so they coincide with the new level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= level_d & ~level_q;
      fall_q <= ~level_d & level_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = 1'b0;
  assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel button debouncer with a shared tick prescaler.
// Define BTN_DEBOUNCE_EDGE_EN to enable rise_pulse/fall_pulse strobes.
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int unsigned      WIDTH          = DEF_WIDTH,
  parameter int unsigned      SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int unsigned      TICK_DIV       = DEF_TICK_DIV,
  parameter int unsigned      DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter logic [WIDTH-1:0] INIT_LEVEL     = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  localparam int unsigned DIV_W = cnt_width(TICK_DIV);

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;

  // Free-running prescaler; tick marks the last count of each period.
  always_comb begin
    tick  = (div_q == DIV_W'(TICK_DIV - 1));
    div_d = tick ? '0 : div_q + DIV_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    btn_debounce_chan #(
      .SYNC_STAGES   (SYNC_STAGES),
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .INIT_BIT      (INIT_LEVEL[g])
    ) u_chan (
      .clk    (clk),
      .reset_n(reset_n),
      .raw_i  (raw_in[g]),
      .tick_i (tick),
      .level_o(level_out[g]),
      .rise_o (rise_pulse[g]),
      .fall_o (fall_pulse[g])
    );
  end

endmodule
